rgb888_to_rgb565_stream: RTL and testbench
==========================================

# rgb888_to_rgb565_stream

Streaming pixel converter from 24-bit RGB888 to 16-bit RGB565, the opposite direction of the display-side RGB565→RGB888 expander. Used on the capture/compositor write path to pack pixels into 16-bit framebuffer words. Optional 4×4 ordered (Bayer) dithering is driven by frame and line markers. The block is a 2-stage valid/ready pipeline with full backpressure support.

## Interface
- DITHER_DEFAULT, 1'b1: value of the dither enable after reset (informational; the live control is `dither_en_i`).
- clk  input  1  system clock
- reset_ni  input  1  asynchronous, active-low reset
- s_valid_i  input  1  input pixel valid
- s_ready_o  output  1  input pixel accepted when `s_valid_i && s_ready_o`
- s_data_i  input  24  {R[23:16], G[15:8], B[7:0]}
- s_sof_i  input  1  pixel is the first of a frame
- s_eol_i  input  1  pixel is the last of a line
- dither_en_i  input  1  1 = Bayer dither, 0 = truncate; sampled per accepted beat
- m_valid_o  output  1  output pixel valid
- m_ready_i  input  1  downstream accepts when `m_valid_o && m_ready_i`
- m_data_o  output  16  {R5[15:11], G6[10:5], B5[4:0]}
- m_sof_o, m_eol_o  output  1 each  markers delayed alongside the pixel

## Operation
- Dither position uses 2-bit column counter `col` and 2-bit row counter `row`.
- Effective position of the accepted pixel: (0,0) if `s_sof_i`, else (`col`,`row`).
- After each accepted beat:
  - `s_eol_i`: `col`←0, `row`←eff_row+1 mod 4.
  - otherwise: `col`←eff_col+1 mod 4, `row`←eff_row.
- Bayer matrix B[row][col], rows: 0 8 2 10 / 12 4 14 6 / 3 11 1 9 / 15 7 13 5.
- Thresholds when dithering: t5 = B>>1 (0..7) for R and B; t6 = B>>2 (0..3) for G. When not dithering: t5 = t6 = 0.
- Per channel, 9-bit sum s = c + t:
  - R/B result = min(s>>3, 31).
  - G result = min(s>>2, 63).
  - Saturation is mandatory; no wrap.
- With dither disabled, conversion is pure truncation. This guarantees an exact round-trip for any pixel produced by the RGB565→RGB888 expander.
- Stage A registers the three 9-bit sums plus markers. Stage B saturates, packs and holds the output.
- Markers travel unchanged with their pixel.

## Timing
- Latency: 2 cycles from input acceptance to `m_valid_o`, when there is no backpressure. Throughput is 1 pixel/cycle.
- `s_ready_o = !vA || !vB || m_ready_i`. This is combinational from `m_ready_i`, with no combinational path from `s_valid_i`.
- Stage B loads when `!vB || m_ready_i`. Stage A loads when it is empty or advancing.
- Capacity is 2 pixels. With `m_ready_i` held low, `s_ready_o` drops after the second accepted pixel.
- While `m_valid_o && !m_ready_i`, `m_data_o`, `m_sof_o` and `m_eol_o` hold stable.
- Simultaneous `s_sof_i` and `s_eol_i` on one beat: position (0,0); afterwards `col`=0, `row`=1.
- Reset values:
  - `m_valid_o`=0, `m_data_o`=0, markers 0.
  - `col`=`row`=0; stage valids 0.
  - `s_ready_o`=1 in the first cycle after reset release.
- Reset asserted mid-stream discards in-flight pixels immediately. Nothing is emitted afterwards until new input arrives.
- Beats where `s_valid_i` is low or not accepted do not advance the counters.

## Structure
- Shared package `rgb_pkg`:
  - Bayer 4×4 constant.
  - `rgb565_t`/`rgb888_t` packed structs.
  - Channel width localparams (5/6/5).
- Sub-module `rgb_quantize_ch`, parameter OUT_BITS (5 or 6): takes an 8-bit channel plus a threshold and returns the saturated result. It is instantiated three times.
- Position counters and handshake live in the top module.

## Test plan
- Dither off, inputs 0x000000, 0xFFFFFF, 0x808080 → 0x0000, 0xFFFF, 0x8410; each appears exactly 2 cycles after acceptance.
- Dither on, `s_sof_i`=1 with 0x7C7C7C, then 0x7C7C7C → 0x7BEF at (0,0), then 0x83F0 at (1,0) where t5=4 and t6=2.
- Dither on, 0xFFFFFF at every position of a 4×4 tile → always 0xFFFF (saturation, no wrap).
- Random `m_ready_i` (including 5 cycles held low during a burst of 3 pixels) → `s_ready_o` low after 2 pixels, no loss, no duplication, order preserved, output stable while stalled.
- Markers: 5 lines of 6 pixels each with `s_eol_i` on pixel 6 → row sequence 0,1,2,3,0; a mid-frame `s_sof_i` resets the position to (0,0); an sof+eol beat gives next row 1.
- Round-trip sweep: all 65536 RGB565 codes expanded by the reference formula, converted with dither off → identical code; reset asserted mid-burst → `m_valid_o` low the same cycle and counters at 0.

Source files
------------

// File: rtl/rgb_pkg.sv
// rgb_pkg: shared types and constants for the RGB888 -> RGB565 stream path.
//   - rgb888_t / rgb565_t : packed pixel layouts, red in the MSBs.
//   - R_BITS/G_BITS/B_BITS : packed channel widths (5/6/5).
//   - SUM_BITS             : width of a channel value plus dither threshold.
//   - bayer_at()           : 4x4 ordered-dither matrix lookup, value 0..15.
package rgb_pkg;

  localparam int R_BITS   = 5;
  localparam int G_BITS   = 6;
  localparam int B_BITS   = 5;
  localparam int SUM_BITS = 9;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    logic [R_BITS-1:0] r;
    logic [G_BITS-1:0] g;
    logic [B_BITS-1:0] b;
  } rgb565_t;

  // Bayer matrix rows (row 0 first):
  //   0  8  2 10 / 12  4 14  6 / 3 11  1  9 / 15  7 13  5
  // Stored as 16 nibbles, entry {row,col} at bit offset {row,col}*4, so the
  // last hex digit is B[0][0].
  localparam logic [63:0] BAYER_TBL = 64'h5D7F_91B3_6E4C_A280;

  function automatic logic [3:0] bayer_at(input logic [1:0] row, input logic [1:0] col);
    logic [5:0] base;
    base = {row, col, 2'b00};
    return BAYER_TBL[base +: 4];
  endfunction

endpackage

// File: rtl/rgb_quantize_ch.sv
// rgb_quantize_ch: one colour channel of the 8-bit -> OUT_BITS quantiser.
// The channel is split across the two pipeline stages of the top level:
//   - ch_i, thr_i -> sum_o : 9-bit sum of the channel and its dither
//                            threshold, registered by the parent (stage A).
//   - sum_i       -> q_o   : the registered sum scaled down to OUT_BITS and
//                            saturated to all-ones (stage B).
// Ports:
//   ch_i  [7:0]          8-bit channel value
//   thr_i [2:0]          dither threshold (0 when dithering is off)
//   sum_o [SUM_BITS-1:0] ch_i + thr_i
//   sum_i [SUM_BITS-1:0] registered sum from stage A
//   q_o   [OUT_BITS-1:0] saturated quantised channel
module rgb_quantize_ch
  import rgb_pkg::*;
#(
  parameter int OUT_BITS = 5
) (
  input  logic [7:0]          ch_i,
  input  logic [2:0]          thr_i,
  output logic [SUM_BITS-1:0] sum_o,
  input  logic [SUM_BITS-1:0] sum_i,
  output logic [OUT_BITS-1:0] q_o
);

  localparam int SHIFT = 8 - OUT_BITS;

  logic [SUM_BITS-1:0] shifted;

  always_comb begin
    sum_o   = {1'b0, ch_i} + {6'b000000, thr_i};
    shifted = sum_i >> SHIFT;
    // Any bit above the output width means the dithered value crossed full
    // scale; clamp instead of wrapping back to black.
    if (|shifted[SUM_BITS-1:OUT_BITS]) begin
      q_o = '1;
    end else begin
      q_o = shifted[OUT_BITS-1:0];
    end
  end

endmodule

// File: rtl/rgb888_to_rgb565_stream.sv
// rgb888_to_rgb565_stream: streaming RGB888 -> RGB565 packer with optional
// 4x4 ordered dither, two-stage valid/ready pipeline.
// Ports:
//   clk, reset_ni           clock, asynchronous active-low reset
//   s_valid_i/s_ready_o     input handshake
//   s_data_i [23:0]         {R,G,B} 8 bits each
//   s_sof_i / s_eol_i       first pixel of frame / last pixel of line
//   dither_en_i             1 = Bayer dither, 0 = truncate (per accepted beat)
//   m_valid_o/m_ready_i     output handshake
//   m_data_o [15:0]         {R5,G6,B5}
//   m_sof_o / m_eol_o       markers travelling with the pixel
// Parameter DITHER_DEFAULT records the intended power-on dither setting; the
// live control is dither_en_i.
module rgb888_to_rgb565_stream
  import rgb_pkg::*;
#(
  parameter logic DITHER_DEFAULT = 1'b1
) (
  input  logic        clk,
  input  logic        reset_ni,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [23:0] s_data_i,
  input  logic        s_sof_i,
  input  logic        s_eol_i,
  input  logic        dither_en_i,
  output logic        m_valid_o,
  input  logic        m_ready_i,
  output logic [15:0] m_data_o,
  output logic        m_sof_o,
  output logic        m_eol_o
);

  // Handshake: a beat transfers on a port exactly when valid && ready on the
  // same rising edge. Valid never waits on ready, and once m_valid_o is high
  // the output word and markers are held until m_ready_i takes it. s_ready_o
  // depends only on pipeline state and m_ready_i, never on s_valid_i.

  logic unused_dither_default;
  assign unused_dither_default = DITHER_DEFAULT;

  rgb888_t pix;
  assign pix = rgb888_t'(s_data_i);

  // Dither position counters.
  logic [1:0] col_q, col_d;
  logic [1:0] row_q, row_d;
  logic [1:0] eff_col, eff_row;
  logic [3:0] bayer_val;
  logic [2:0] t5;
  logic [1:0] t6;

  // Handshake.
  logic accept;
  logic load_b;

  // Stage A: raw sums and markers.
  logic                va_q, va_d;
  logic [SUM_BITS-1:0] sum_r_q, sum_r_d;
  logic [SUM_BITS-1:0] sum_g_q, sum_g_d;
  logic [SUM_BITS-1:0] sum_b_q, sum_b_d;
  logic                sof_a_q, sof_a_d;
  logic                eol_a_q, eol_a_d;

  // Stage B: packed output word and markers.
  logic    vb_q, vb_d;
  rgb565_t data_b_q, data_b_d;
  logic    sof_b_q, sof_b_d;
  logic    eol_b_q, eol_b_d;

  // Quantiser taps.
  logic [SUM_BITS-1:0] sum_r_c, sum_g_c, sum_b_c;
  logic [R_BITS-1:0]   q_r;
  logic [G_BITS-1:0]   q_g;
  logic [B_BITS-1:0]   q_b;

  rgb_quantize_ch #(.OUT_BITS(R_BITS)) u_q_r (
    .ch_i  (pix.r),
    .thr_i (t5),
    .sum_o (sum_r_c),
    .sum_i (sum_r_q),
    .q_o   (q_r)
  );

  rgb_quantize_ch #(.OUT_BITS(G_BITS)) u_q_g (
    .ch_i  (pix.g),
    .thr_i ({1'b0, t6}),
    .sum_o (sum_g_c),
    .sum_i (sum_g_q),
    .q_o   (q_g)
  );

  rgb_quantize_ch #(.OUT_BITS(B_BITS)) u_q_b (
    .ch_i  (pix.b),
    .thr_i (t5),
    .sum_o (sum_b_c),
    .sum_i (sum_b_q),
    .q_o   (q_b)
  );

  // Handshake and dither position.
  always_comb begin
    load_b    = !vb_q || m_ready_i;
    // Stage A can take a new pixel when it is empty or its pixel is moving
    // into stage B on this edge.
    s_ready_o = !va_q || load_b;
    accept    = s_valid_i && s_ready_o;

    // A start-of-frame pixel is always placed at the matrix origin,
    // whatever the counters held.
    eff_col   = s_sof_i ? 2'd0 : col_q;
    eff_row   = s_sof_i ? 2'd0 : row_q;
    bayer_val = bayer_at(eff_row, eff_col);
    t5        = dither_en_i ? bayer_val[3:1] : 3'd0;
    t6        = dither_en_i ? bayer_val[3:2] : 2'd0;

    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (s_eol_i) begin
        col_d = 2'd0;
        row_d = eff_row + 2'd1;
      end else begin
        col_d = eff_col + 2'd1;
        row_d = eff_row;
      end
    end
  end

  // Stage A next state.
  always_comb begin
    va_d    = va_q;
    sum_r_d = sum_r_q;
    sum_g_d = sum_g_q;
    sum_b_d = sum_b_q;
    sof_a_d = sof_a_q;
    eol_a_d = eol_a_q;
    if (accept) begin
      va_d    = 1'b1;
      sum_r_d = sum_r_c;
      sum_g_d = sum_g_c;
      sum_b_d = sum_b_c;
      sof_a_d = s_sof_i;
      eol_a_d = s_eol_i;
    end else if (load_b) begin
      // Contents moved on to stage B and nothing replaced them.
      va_d = 1'b0;
    end
  end

  // Stage B next state.
  always_comb begin
    vb_d     = vb_q;
    data_b_d = data_b_q;
    sof_b_d  = sof_b_q;
    eol_b_d  = eol_b_q;
    if (load_b) begin
      vb_d = va_q;
      if (va_q) begin
        data_b_d = '{r: q_r, g: q_g, b: q_b};
        sof_b_d  = sof_a_q;
        eol_b_d  = eol_a_q;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      col_q    <= 2'd0;
      row_q    <= 2'd0;
      va_q     <= 1'b0;
      sum_r_q  <= '0;
      sum_g_q  <= '0;
      sum_b_q  <= '0;
      sof_a_q  <= 1'b0;
      eol_a_q  <= 1'b0;
      vb_q     <= 1'b0;
      data_b_q <= '0;
      sof_b_q  <= 1'b0;
      eol_b_q  <= 1'b0;
    end else begin
      col_q    <= col_d;
      row_q    <= row_d;
      va_q     <= va_d;
      sum_r_q  <= sum_r_d;
      sum_g_q  <= sum_g_d;
      sum_b_q  <= sum_b_d;
      sof_a_q  <= sof_a_d;
      eol_a_q  <= eol_a_d;
      vb_q     <= vb_d;
      data_b_q <= data_b_d;
      sof_b_q  <= sof_b_d;
      eol_b_q  <= eol_b_d;
    end
  end

  assign m_valid_o = vb_q;
  assign m_data_o  = data_b_q;
  assign m_sof_o   = sof_b_q;
  assign m_eol_o   = eol_b_q;

endmodule

// File: tb/tb_rgb888_to_rgb565_stream.sv
// Testbench for rgb888_to_rgb565_stream: directed vectors driven through a
// valid/ready driver, expected words queued at acceptance and checked by an
// independent output monitor.
module tb_rgb888_to_rgb565_stream;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset_ni;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] s_data;
  logic        s_sof;
  logic        s_eol;
  logic        dither_en;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_sof;
  logic        m_eol;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rgb888_to_rgb565_stream #(.DITHER_DEFAULT(1'b1)) dut (
    .clk         (clk),
    .reset_ni    (reset_ni),
    .s_valid_i   (s_valid),
    .s_ready_o   (s_ready),
    .s_data_i    (s_data),
    .s_sof_i     (s_sof),
    .s_eol_i     (s_eol),
    .dither_en_i (dither_en),
    .m_valid_o   (m_valid),
    .m_ready_i   (m_ready),
    .m_data_o    (m_data),
    .m_sof_o     (m_sof),
    .m_eol_o     (m_eol)
  );

  // ---------------- scoreboard state ----------------
  logic [17:0] exp_q[$];   // {sof, eol, data}
  int          acc_q[$];   // cycle of acceptance
  int          errors = 0;
  int          checks = 0;
  int          pos_col;
  int          pos_row;
  bit          rand_rdy;
  int          stall_left;
  bit          lat_chk;
  bit          prev_stall = 1'b0;
  logic [17:0] prev_word  = '0;

  int bayer_tb[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};

  function automatic logic [15:0] ref_conv(input logic [23:0] p, input int row, input int col,
                                           input bit d);
    int b, t5, t6, r, g, bl;
    b  = bayer_tb[row][col];
    t5 = d ? b / 2 : 0;
    t6 = d ? b / 4 : 0;
    r  = (int'(p[23:16]) + t5) / 8;
    if (r > 31) r = 31;
    g  = (int'(p[15:8]) + t6) / 4;
    if (g > 63) g = 63;
    bl = (int'(p[7:0]) + t5) / 8;
    if (bl > 31) bl = 31;
    return 16'(r * 2048 + g * 32 + bl);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance to just after the next rising edge and update m_ready.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      m_ready = ($urandom_range(0, 3) != 0);
    end else if (stall_left > 0) begin
      stall_left--;
      if (stall_left == 0) m_ready = 1'b1;
    end
  endtask

  task automatic send(input logic [23:0] d, input bit sof, input bit eol, input bit dith,
                      input bit use_exp, input logic [15:0] exp_given);
    int ec, er, waited;
    logic [15:0] e;
    ec = sof ? 0 : pos_col;
    er = sof ? 0 : pos_row;
    e  = use_exp ? exp_given : ref_conv(d, er, ec, dith);
    s_valid   = 1'b1;
    s_data    = d;
    s_sof     = sof;
    s_eol     = eol;
    dither_en = dith;
    waited    = 0;
    @(negedge clk);
    while (!s_ready && waited < 500) begin
      tick();
      @(negedge clk);
      waited++;
    end
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: s_ready_o=0 after %0d cycles, expected 1", waited);
    end else begin
      exp_q.push_back({sof, eol, e});
      acc_q.push_back(cyc);
      if (eol) begin
        pos_col = 0;
        pos_row = (er + 1) % 4;
      end else begin
        pos_col = (ec + 1) % 4;
        pos_row = er;
      end
    end
    tick();
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_eol   = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < 2000) begin
      tick();
      k++;
    end
    check("drain_pending", 32'(exp_q.size()), 0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [17:0] w;
    int          a;
    if (!reset_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 1);
        check("stall_hold", 32'({m_sof, m_eol, m_data}), 32'(prev_word));
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h, expected no output", m_data);
        end else begin
          w = exp_q.pop_front();
          a = acc_q.pop_front();
          check("out_word", 32'({m_sof, m_eol, m_data}), 32'(w));
          if (lat_chk) check("latency", 32'(cyc - a), 2);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_word  = {m_sof, m_eol, m_data};
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] cd;
    logic [23:0] d;
    reset_ni   = 1'b0;
    s_valid    = 1'b0;
    s_data     = '0;
    s_sof      = 1'b0;
    s_eol      = 1'b0;
    dither_en  = 1'b0;
    m_ready    = 1'b1;
    rand_rdy   = 1'b0;
    stall_left = 0;
    lat_chk    = 1'b0;
    pos_col    = 0;
    pos_row    = 0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_m_sof", 32'(m_sof), 0);
    check("rst_m_eol", 32'(m_eol), 0);
    reset_ni = 1'b1;
    @(negedge clk);
    check("post_rst_s_ready", 32'(s_ready), 1);
    check("post_rst_m_valid", 32'(m_valid), 0);
    tick();

    // Truncation, two-cycle latency.
    lat_chk = 1'b1;
    send(24'h000000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    send(24'hFFFFFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'hFFFF);
    send(24'h808080, 1'b0, 1'b0, 1'b0, 1'b1, 16'h8410);
    wait_drain();
    lat_chk = 1'b0;

    // Dither at (0,0) then (1,0).
    send(24'h7C7C7C, 1'b1, 1'b0, 1'b1, 1'b1, 16'h7BEF);
    send(24'h7C7C7C, 1'b0, 1'b0, 1'b1, 1'b1, 16'h83F0);
    wait_drain();

    // Full white across a 4x4 tile saturates everywhere.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        send(24'hFFFFFF, (r == 0 && c == 0), (c == 3), 1'b1, 1'b1, 16'hFFFF);
      end
    end
    wait_drain();

    // Line/frame markers: 5 lines of 6 pixels.
    for (int l = 0; l < 5; l++) begin
      for (int p = 0; p < 6; p++) begin
        send(24'h7C7D7F, (l == 0 && p == 0), (p == 5), 1'b1, 1'b0, 16'h0);
      end
    end
    // Mid-frame sof, then a combined sof+eol beat.
    send(24'h7C7D7F, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    send(24'h7C7D7F, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    send(24'h7C7D7F, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    send(24'h7C7D7F, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    send(24'h7C7D7F, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0);
    send(24'h7C7D7F, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    send(24'h7C7D7F, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    wait_drain();

    // Capacity: two pixels fill the pipe while m_ready is low.
    m_ready = 1'b0;
    tick();
    send(24'h112233, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    send(24'h445566, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0);
    @(negedge clk);
    check("full_s_ready", 32'(s_ready), 0);
    check("full_m_valid", 32'(m_valid), 1);
    stall_left = 5;
    send(24'h778899, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    wait_drain();

    // Random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 24; i++) begin
      d = {8'(i * 37), 8'(i * 91 + 5), 8'(255 - i * 11)};
      send(d, (i == 0), (i % 5 == 4), i[0], 1'b0, 16'h0);
    end
    wait_drain();
    rand_rdy = 1'b0;
    m_ready  = 1'b1;
    tick();

    // Round trip of every RGB565 code through the reference expander.
    for (int code = 0; code < 65536; code++) begin
      cd = 16'(code);
      d  = {cd[15:11], cd[15:13], cd[10:5], cd[10:9], cd[4:0], cd[4:2]};
      send(d, 1'b0, 1'b0, 1'b0, 1'b1, cd);
    end
    wait_drain();

    // Reset mid-burst.
    m_ready = 1'b0;
    tick();
    send(24'h7C7C7C, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0);
    send(24'hFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0);
    reset_ni = 1'b0;
    #1;
    check("midrst_m_valid", 32'(m_valid), 0);
    check("midrst_m_data", 32'(m_data), 0);
    check("midrst_s_ready", 32'(s_ready), 1);
    exp_q.delete();
    acc_q.delete();
    pos_col = 0;
    pos_row = 0;
    m_ready = 1'b1;
    tick();
    reset_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("idle_after_rst", 32'(m_valid), 0);
      tick();
    end
    // Counters restarted at (0,0): no sof, still the origin threshold.
    send(24'h7C7C7C, 1'b0, 1'b0, 1'b1, 1'b1, 16'h7BEF);
    send(24'h7C7C7C, 1'b0, 1'b0, 1'b1, 1'b1, 16'h83F0);
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
